// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one mul/div request through the shared iterative units.
// Optional last-result reuse is compiled in with `define MULDIV_REUSE_EN.

module muldiv_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   input  logic [3:0]         req_op,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   output logic               req_ready,
   input  logic               flush,
   output logic               resp_valid,
   output logic [WIDTH-1:0]   resp_data,
   input  logic               resp_ready,
   output logic               busy,
   output logic               mul_valid,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic               mul_done,
   input  logic [2*WIDTH-1:0] mul_c,
   output logic               div_valid,
   output logic               div_word,
   output logic [WIDTH-1:0]   div_a,
   output logic [WIDTH-1:0]   div_b,
   input  logic               div_done,
   input  logic [2*WIDTH-1:0] div_c
);

   localparam int HW = 32;
   localparam int DW = 2 * WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_HOLD,
      S_DRAIN
   } state_e;

   function automatic logic [WIDTH-1:0] prep(
      input logic [WIDTH-1:0] x,
      input logic             word,
      input logic             neg
   );
      logic [HW-1:0] lo;
      lo = neg ? -x[HW-1:0] : x[HW-1:0];
      if (word)
         prep = {{(WIDTH-HW){1'b0}}, lo};
      else
         prep = neg ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] sext32(
      input logic [HW-1:0] v
   );
      sext32 = {{(WIDTH-HW){v[HW-1]}}, v};
   endfunction

   state_e           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [DW-1:0]    corr_q, corr_d;

   logic             req_word;
   logic             req_div;
   logic             req_uns;
   logic             req_sa;
   logic             req_sb;
   logic [WIDTH-1:0] req_pa;
   logic [WIDTH-1:0] req_pb;
   logic             req_dz;

   logic [DW-1:0]    mul_fix;
   logic [DW-1:0]    div_fix;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] sel;
   logic [WIDTH-1:0] res;
   logic             idle;
   logic             hold;

`ifdef MULDIV_REUSE_EN
   logic             e_v_q, e_v_d;
   logic [DW-1:0]    e_corr_q, e_corr_d;
   logic [WIDTH-1:0] e_a_q, e_a_d;
   logic [WIDTH-1:0] e_b_q, e_b_d;
   logic             e_div_q, e_div_d;
   logic             e_word_q, e_word_d;
   logic             e_uns_q, e_uns_d;
   logic             hit;
`endif

   // Signs come from bit 31 on word ops; unsigned ops never negate.
   always_comb begin
      req_word = req_op[3];
      req_div  = req_op[2];
      req_uns  = req_op[0];
      req_sa   = !req_uns &&
                 (req_word ? req_a[HW-1] : req_a[WIDTH-1]);
      req_sb   = !req_uns &&
                 (req_word ? req_b[HW-1] : req_b[WIDTH-1]);
      req_pa   = prep(req_a, req_word, req_sa);
      req_pb   = prep(req_b, req_word, req_sb);
      req_dz   = req_div && (req_pb == '0);
   end

`ifdef MULDIV_REUSE_EN
   assign hit = e_v_q &&
                (e_a_q == req_a) &&
                (e_b_q == req_b) &&
                (e_div_q == req_op[2]) &&
                (e_word_q == req_op[3]) &&
                (e_uns_q == req_op[0]);
`endif

   always_comb begin
      div_quo = div_c[WIDTH-1:0];
      div_rem = div_c[DW-1:WIDTH];
      mul_fix = (sa_q ^ sb_q) ? -mul_c : mul_c;
      div_fix = {sa_q ? -div_rem : div_rem,
                 (sa_q ^ sb_q) ? -div_quo : div_quo};
   end

   always_comb begin
      sel = op_q[1] ? corr_q[DW-1:WIDTH] : corr_q[WIDTH-1:0];
      if (op_q[3] && !op_q[2])
         res = sext32(corr_q[HW-1:0]);
      else if (op_q[3])
         res = sext32(sel[HW-1:0]);
      else
         res = sel;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      a_d     = a_q;
      b_d     = b_q;
      corr_d  = corr_q;
`ifdef MULDIV_REUSE_EN
      e_v_d    = e_v_q;
      e_corr_d = e_corr_q;
      e_a_d    = e_a_q;
      e_b_d    = e_b_q;
      e_div_d  = e_div_q;
      e_word_d = e_word_q;
      e_uns_d  = e_uns_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               op_d = req_op;
               sa_d = req_sa;
               sb_d = req_sb;
               a_d  = req_pa;
               b_d  = req_pb;
               if (req_dz) begin
                  // Remainder slot holds the raw dividend; word select sign-extends it.
                  corr_d  = {req_a, {WIDTH{1'b1}}};
                  state_d = S_HOLD;
`ifdef MULDIV_REUSE_EN
               end else if (hit) begin
                  corr_d  = e_corr_q;
                  state_d = S_HOLD;
`endif
               end else begin
                  state_d = req_div ? S_DIV : S_MUL;
`ifdef MULDIV_REUSE_EN
                  e_v_d    = 1'b0;
                  e_a_d    = req_a;
                  e_b_d    = req_b;
                  e_div_d  = req_op[2];
                  e_word_d = req_op[3];
                  e_uns_d  = req_op[0];
`endif
               end
            end
         end
         S_MUL: begin
            // A done coinciding with flush ends the unit's job; nothing to drain.
            if (flush) begin
               state_d = mul_done ? S_IDLE : S_DRAIN;
            end else if (mul_done) begin
               corr_d  = mul_fix;
               state_d = S_HOLD;
`ifdef MULDIV_REUSE_EN
               e_v_d    = 1'b1;
               e_corr_d = mul_fix;
`endif
            end
         end
         S_DIV: begin
            if (flush) begin
               state_d = div_done ? S_IDLE : S_DRAIN;
            end else if (div_done) begin
               corr_d  = div_fix;
               state_d = S_HOLD;
`ifdef MULDIV_REUSE_EN
               e_v_d    = 1'b1;
               e_corr_d = div_fix;
`endif
            end
         end
         S_HOLD: begin
            if (flush || resp_ready)
               state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (op_q[2] ? div_done : mul_done)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef MULDIV_REUSE_EN
      if (flush)
         e_v_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         corr_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         a_q     <= a_d;
         b_q     <= b_d;
         corr_q  <= corr_d;
      end
   end

`ifdef MULDIV_REUSE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_v_q    <= 1'b0;
         e_corr_q <= '0;
         e_a_q    <= '0;
         e_b_q    <= '0;
         e_div_q  <= 1'b0;
         e_word_q <= 1'b0;
         e_uns_q  <= 1'b0;
      end else begin
         e_v_q    <= e_v_d;
         e_corr_q <= e_corr_d;
         e_a_q    <= e_a_d;
         e_b_q    <= e_b_d;
         e_div_q  <= e_div_d;
         e_word_q <= e_word_d;
         e_uns_q  <= e_uns_d;
      end
   end
`endif

   assign idle = (state_q == S_IDLE);
   assign hold = (state_q == S_HOLD);

   // A flush in the same cycle wins, so neither handshake may complete.
   assign req_ready  = idle && !flush;
   assign resp_valid = hold && !flush;
   assign resp_data  = hold ? res : '0;
   assign busy       = !idle;

   assign mul_valid = (state_q == S_MUL) ||
                      ((state_q == S_DRAIN) && !op_q[2]);
   assign div_valid = (state_q == S_DIV) ||
                      ((state_q == S_DRAIN) && op_q[2]);
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign div_a     = a_q;
   assign div_b     = b_q;
   assign div_word  = op_q[3];

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors with a response scoreboard
// and behavioural iterative multiplier/divider models.

module tb_muldiv_ctrl;

   localparam int W    = 64;
   localparam int MLAT = 4;
   localparam int DLAT = 6;

   logic           clk;
   logic           reset;
   logic           req_valid;
   logic [3:0]     req_op;
   logic [W-1:0]   req_a;
   logic [W-1:0]   req_b;
   logic           req_ready;
   logic           flush;
   logic           resp_valid;
   logic [W-1:0]   resp_data;
   logic           resp_ready;
   logic           busy;
   logic           mul_valid;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_b;
   logic           mul_done;
   logic [2*W-1:0] mul_c;
   logic           div_valid;
   logic           div_word;
   logic [W-1:0]   div_a;
   logic [W-1:0]   div_b;
   logic           div_done;
   logic [2*W-1:0] div_c;

   int n_chk  = 0;
   int n_fail = 0;
   int n_resp = 0;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   logic [W-1:0] mon_e;
   string        mon_nm;

   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .busy       (busy),
      .mul_valid  (mul_valid),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_done   (mul_done),
      .mul_c      (mul_c),
      .div_valid  (div_valid),
      .div_word   (div_word),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_done   (div_done),
      .div_c      (div_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int mcnt;
   int dcnt;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_done <= 1'b0;
         div_done <= 1'b0;
         mul_c    <= '0;
         div_c    <= '0;
         mcnt     <= 0;
         dcnt     <= 0;
      end else begin
         mul_done <= 1'b0;
         div_done <= 1'b0;
         if (mul_valid && !mul_done) begin
            if (mcnt == MLAT) begin
               mul_done <= 1'b1;
               mul_c    <= (2*W)'(mul_a) * (2*W)'(mul_b);
               mcnt     <= 0;
            end else begin
               mcnt <= mcnt + 1;
            end
         end
         if (div_valid && !div_done) begin
            if (dcnt == DLAT) begin
               div_done <= 1'b1;
               div_c    <= (div_b == '0) ? '0 :
                           {div_a % div_b, div_a / div_b};
               dcnt     <= 0;
            end else begin
               dcnt <= dcnt + 1;
            end
         end
      end
   end

   task automatic chk(input string nm,
                      input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: bound expired", nm);
   endtask

   always @(negedge clk) begin
      if (reset && resp_valid && resp_ready) begin
         n_resp++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: got %h expected none",
                     resp_data);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            chk(mon_nm, resp_data, mon_e);
         end
      end
   end

   task automatic expect_resp(input string nm, input logic [W-1:0] e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic issue(input logic [3:0]   op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
      bit acc;
      acc       = 1'b0;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!acc) bad("accept_timeout");
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = !busy && (exp_q.size() == 0);
      end
      if (!ok) bad(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input string nm);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = resp_valid;
      end
      if (!ok) bad(nm);
   endtask

   task automatic vec(input string        nm,
                      input logic [3:0]   op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic [W-1:0] e);
      expect_resp(nm, e);
      issue(op, a, b);
      wait_idle({nm, "_idle"});
   endtask

   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;
   localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;

   initial begin
      bit dv_ok;
      bit rr_ok;
      bit gone;
      int cyc;
      int r0;

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_unit_valid", {mul_valid, div_valid}, 0);
      chk("rst_resp_data", resp_data, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      expect_resp("mul_neg", 64'hFFFF_FFFF_FFFF_FFF1);
      issue(4'b0000, M3, 64'd5);
      @(negedge clk);
      chk("mul_start_valid", mul_valid, 1);
      chk("mul_start_a", mul_a, 64'd3);
      chk("mul_start_b", mul_b, 64'd5);
      @(posedge clk);
      #1;
      wait_idle("mul_neg_idle");

      expect_resp("mulh_same_ops", ONES);
      issue(4'b0010, M3, 64'd5);
      @(negedge clk);
`ifdef MULDIV_REUSE_EN
      chk("reuse_resp_valid", resp_valid, 1);
      chk("reuse_mul_valid", mul_valid, 0);
`else
      chk("noreuse_mul_valid", mul_valid, 1);
      chk("noreuse_resp_valid", resp_valid, 0);
`endif
      @(posedge clk);
      #1;
      wait_idle("mulh_same_idle");

      vec("mulh_m1", 4'b0010, ONES, ONES, 64'd0);
      vec("mulhu_m1", 4'b0011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
      vec("div_ovf", 4'b0100, MIN, ONES, MIN);
      vec("rem_ovf", 4'b0110, MIN, ONES, 64'd0);
      vec("divu", 4'b0101, 64'd100, 64'd7, 64'd14);
      vec("remu", 4'b0111, 64'd100, 64'd7, 64'd2);
      vec("div_neg", 4'b0100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
          64'hFFFF_FFFF_FFFF_FFF2);
      vec("rem_neg", 4'b0110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
          64'hFFFF_FFFF_FFFF_FFFE);
      vec("mulw", 4'b1000, 64'h7FFF_FFFF, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFE);
      vec("divw_ovf", 4'b1100, 64'hFFFF_FFFF_8000_0000, ONES,
          64'hFFFF_FFFF_8000_0000);
      vec("remw_ovf", 4'b1110, 64'hFFFF_FFFF_8000_0000, ONES, 64'd0);
      vec("divuw_sext", 4'b1101, 64'hFFFF_FFFF, 64'd1, ONES);
      vec("div_by0", 4'b0100, 64'd5, 64'd0, ONES);
      vec("rem_by0", 4'b0110, 64'd5, 64'd0, 64'd5);

      expect_resp("divuw_by0", ONES);
      issue(4'b1101, 64'h1_8000_0000, 64'd0);
      @(negedge clk);
      chk("dz_resp_latency", resp_valid, 1);
      chk("dz_div_valid", div_valid, 0);
      @(posedge clk);
      #1;
      wait_idle("divuw_by0_idle");
      vec("remuw_by0", 4'b1111, 64'h1_8000_0000, 64'd0,
          64'hFFFF_FFFF_8000_0000);

      resp_ready = 1'b0;
      expect_resp("mulu_backpressure", 64'd42);
      issue(4'b0001, 64'd6, 64'd7);
      wait_resp("bp_resp_timeout");
      repeat (3) @(negedge clk);
      chk("bp_resp_held", resp_valid, 1);
      chk("bp_data_held", resp_data, 64'd42);
      @(posedge clk);
      #1 resp_ready = 1'b1;
      wait_idle("bp_idle");

      resp_ready = 1'b0;
      issue(4'b0001, 64'd9, 64'd9);
      wait_resp("fh_resp_timeout");
      @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_hold_resp", resp_valid, 0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_hold_idle", busy, 0);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;

      issue(4'b0101, 64'd1000, 64'd3);
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      r0    = n_resp;
      dv_ok = 1'b1;
      rr_ok = 1'b1;
      gone  = 1'b0;
      cyc   = 0;
      for (int t = 0; t < 100 && !gone; t++) begin
         @(negedge clk);
         if (!busy) begin
            gone = 1'b1;
         end else begin
            cyc++;
            if (!div_valid) dv_ok = 1'b0;
            if (req_ready) rr_ok = 1'b0;
         end
      end
      chk("drain_returns_idle", gone, 1);
      chk("drain_div_valid_held", dv_ok, 1);
      chk("drain_req_ready_low", rr_ok, 1);
      chk("drain_no_resp", n_resp - r0, 0);
      chk("drain_waited", cyc > 0, 1);
      @(posedge clk);
      #1;

      issue(4'b0001, 64'd11, 64'd13);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("areset_mul_valid", mul_valid, 0);
      chk("areset_busy", busy, 0);
      chk("areset_req_ready", req_ready, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      vec("post_reset_mulu", 4'b0001, 64'd11, 64'd13, 64'd143);

      wait_idle("final_idle");
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

endmodule
